// File: rtl/ip_csum_pkg.sv
// rtl/ip_csum_pkg.sv - shared types and helpers for the streaming ones'-complement checksum engine
package ip_csum_pkg;

    localparam int          DEF_DATA_W = 64;
    localparam int          LANES      = DEF_DATA_W / 16;
    localparam logic [15:0] CSUM_OK    = 16'hFFFF;

    typedef struct packed {
        logic [15:0] csum;
        logic        ok;
    } csum_res_t;

    // Two end-around folds are enough to bring any 32-bit sum into 16 bits.
    function automatic logic [15:0] fold16(input logic [31:0] x);
        logic [16:0] s;
        s = {1'b0, x[15:0]} + {1'b0, x[31:16]};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/csum_res_fifo.sv
// rtl/csum_res_fifo.sv - first-word-fall-through result FIFO with occupancy count
module csum_res_fifo
    import ip_csum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  csum_res_t                  push_data,
    input  logic                       pop,
    output csum_res_t                  head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    csum_res_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != (AW+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head reads as zero while empty so the outputs are defined out of reset.
    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/ip_checksum_stream.sv
// rtl/ip_checksum_stream.sv - streaming RFC 1071 checksum: beat sum, accumulate, result FIFO
module ip_checksum_stream
    import ip_csum_pkg::*;
#(
    parameter int DATA_W    = 16 * LANES,
    parameter int RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_keep,
    input  logic                  s_last,
    input  logic [15:0]           s_seed,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           m_csum,
    output logic                  m_ok
);

    localparam int NL = DATA_W / 16;
    localparam int KW = DATA_W / 8;
    localparam int CW = $clog2(RES_DEPTH) + 1;

    logic              accept;
    logic [DATA_W-1:0] masked;
    logic [31:0]       lane_sum;

    logic              sop_q, sop_d;
    logic              a_valid_q, a_valid_d;
    logic              a_last_q, a_last_d;
    logic              a_sop_q, a_sop_d;
    logic [15:0]       a_seed_q, a_seed_d;
    logic [15:0]       a_sum_q, a_sum_d;

    logic              b_valid_q, b_valid_d;
    logic              b_last_q, b_last_d;
    logic [15:0]       acc_q, acc_d;
    logic [15:0]       base;

    csum_res_t         push_res;
    csum_res_t         head;
    logic              push;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;

    always_comb begin
        masked   = '0;
        lane_sum = '0;
        for (int i = 0; i < KW; i++) begin
            masked[i*8 +: 8] = s_keep[i] ? s_data[i*8 +: 8] : 8'h00;
        end
        for (int l = 0; l < NL; l++) begin
            lane_sum = lane_sum + {16'h0, masked[l*16 +: 16]};
        end
    end

    // Every last beat still in A or B already owns a FIFO slot; non-last beats are gated too.
    always_comb begin
        occupancy = {1'b0, fifo_count}
                  + (CW+1)'(a_valid_q & a_last_q)
                  + (CW+1)'(b_valid_q & b_last_q);
        s_ready   = rst_n && (occupancy < (CW+1)'(RES_DEPTH));
        accept    = s_valid && s_ready;
    end

    always_comb begin
        sop_d     = sop_q;
        a_valid_d = accept;
        a_last_d  = a_last_q;
        a_sop_d   = a_sop_q;
        a_seed_d  = a_seed_q;
        a_sum_d   = a_sum_q;
        if (accept) begin
            a_last_d = s_last;
            a_sop_d  = sop_q;
            a_seed_d = s_seed;
            a_sum_d  = fold16(lane_sum);
            sop_d    = s_last;
        end
    end

    always_comb begin
        b_valid_d = a_valid_q;
        b_last_d  = a_last_q;
        base      = a_sop_q ? a_seed_q : acc_q;
        acc_d     = acc_q;
        if (a_valid_q) begin
            acc_d = fold16({16'h0, base} + {16'h0, a_sum_q});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sop_q     <= 1'b1;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_sop_q   <= 1'b0;
            a_seed_q  <= '0;
            a_sum_q   <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            sop_q     <= sop_d;
            a_valid_q <= a_valid_d;
            a_last_q  <= a_last_d;
            a_sop_q   <= a_sop_d;
            a_seed_q  <= a_seed_d;
            a_sum_q   <= a_sum_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        push          = b_valid_q && b_last_q;
        push_res.csum = ~acc_q;
        push_res.ok   = (acc_q == CSUM_OK);
    end

    csum_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_res),
        .pop        (m_ready),
        .head       (head),
        .head_valid (m_valid),
        .count      (fifo_count)
    );

    assign m_csum = head.csum;
    assign m_ok   = head.ok;

endmodule
